// File: rtl/pipe_pkg.sv
// Shared definitions for pipeline stage buffers: occupancy state encoding
// and the default exception-code width.
package pipe_pkg;

    localparam int PIPE_EX_W = 6;

    typedef enum logic [1:0] {
        STG_EMPTY = 2'd0,
        STG_WAIT  = 2'd1,
        STG_FULL  = 2'd2
    } stg_state_e;

endpackage

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with valid/allow handshake, multi-source
// flush and capture of a late (multicycle) result for the current occupant.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W  = 64,
    parameter int EX_W    = PIPE_EX_W,
    parameter int LATE_W  = 64,
    parameter int FLUSH_N = 3
) (
    input  logic                clock,
    input  logic                resetn,
    input  logic                in_valid,
    input  logic [DATA_W-1:0]   in_payload,
    input  logic [EX_W-1:0]     in_ex,
    input  logic                in_need_late,
    output logic                in_allow,
    output logic                out_valid,
    output logic [DATA_W-1:0]   out_payload,
    output logic [EX_W-1:0]     out_ex,
    output logic [LATE_W-1:0]   out_late_data,
    input  logic                out_allow,
    input  logic                late_valid,
    input  logic [LATE_W-1:0]   late_data,
    input  logic [FLUSH_N-1:0]  flush_req
);

    stg_state_e              state_q, state_d;
    logic [DATA_W-1:0]       payload_q;
    logic [EX_W-1:0]         ex_q;
    logic [LATE_W-1:0]       late_q;
    logic                    kill;
    logic                    load;

    assign kill      = |flush_req;
    assign out_valid = (state_q == STG_FULL);
    assign in_allow  = (state_q == STG_EMPTY) | ((state_q == STG_FULL) & out_allow);
    assign load      = in_allow & in_valid & ~kill;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= STG_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            STG_EMPTY: begin
                if (load) state_d = in_need_late ? STG_WAIT : STG_FULL;
            end
            STG_WAIT: begin
                if (kill)            state_d = STG_EMPTY;
                else if (late_valid) state_d = STG_FULL;
            end
            STG_FULL: begin
                if (kill) begin
                    state_d = STG_EMPTY;
                end else if (out_allow) begin
                    if (load) state_d = in_need_late ? STG_WAIT : STG_FULL;
                    else      state_d = STG_EMPTY;
                end
            end
            default: state_d = STG_EMPTY;
        endcase
    end

    // Late result is taken only while waiting, and never in a flush cycle.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            payload_q <= '0;
            ex_q      <= '0;
            late_q    <= '0;
        end else if (load) begin
            payload_q <= in_payload;
            ex_q      <= in_ex;
            late_q    <= '0;
        end else if ((state_q == STG_WAIT) && late_valid && !kill) begin
            late_q    <= late_data;
        end
    end

    assign out_payload   = payload_q;
    assign out_ex        = ex_q;
    assign out_late_data = late_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed self-checking bench for pipe_stage_reg: streaming, backpressure,
// late capture, flush, spurious late pulses and asynchronous reset.
module tb_pipe_stage_reg;

    localparam int DATA_W  = 64;
    localparam int EX_W    = 6;
    localparam int LATE_W  = 64;
    localparam int FLUSH_N = 3;

    logic                clock;
    logic                resetn;
    logic                in_valid;
    logic [DATA_W-1:0]   in_payload;
    logic [EX_W-1:0]     in_ex;
    logic                in_need_late;
    logic                in_allow;
    logic                out_valid;
    logic [DATA_W-1:0]   out_payload;
    logic [EX_W-1:0]     out_ex;
    logic [LATE_W-1:0]   out_late_data;
    logic                out_allow;
    logic                late_valid;
    logic [LATE_W-1:0]   late_data;
    logic [FLUSH_N-1:0]  flush_req;

    int checks;
    int passed;

    pipe_stage_reg #(
        .DATA_W  (DATA_W),
        .EX_W    (EX_W),
        .LATE_W  (LATE_W),
        .FLUSH_N (FLUSH_N)
    ) dut (
        .clock         (clock),
        .resetn        (resetn),
        .in_valid      (in_valid),
        .in_payload    (in_payload),
        .in_ex         (in_ex),
        .in_need_late  (in_need_late),
        .in_allow      (in_allow),
        .out_valid     (out_valid),
        .out_payload   (out_payload),
        .out_ex        (out_ex),
        .out_late_data (out_late_data),
        .out_allow     (out_allow),
        .late_valid    (late_valid),
        .late_data     (late_data),
        .flush_req     (flush_req)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        resetn       = 1'b0;
        in_valid     = 1'b0;
        in_payload   = '0;
        in_ex        = '0;
        in_need_late = 1'b0;
        out_allow    = 1'b0;
        late_valid   = 1'b0;
        late_data    = '0;
        flush_req    = '0;
        #12;
        checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid); else passed++;
        checks++; if (in_allow !== 1'b1) $display("FAIL reset_in_allow got %b want 1", in_allow); else passed++;
        checks++; if (out_payload !== 64'h0) $display("FAIL reset_payload got %h want 0", out_payload); else passed++;
        checks++; if (out_late_data !== 64'h0) $display("FAIL reset_late got %h want 0", out_late_data); else passed++;
        @(negedge clock);
        resetn = 1'b1;
        step();
    endtask

    task automatic test_stream();
        logic [DATA_W-1:0] exp_pl [3];
        exp_pl[0] = 64'h1; exp_pl[1] = 64'h2; exp_pl[2] = 64'h3;
        in_valid = 1'b1; out_allow = 1'b1; in_need_late = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_payload = exp_pl[i];
            in_ex      = (i == 2) ? 6'h2A : 6'h00;
            #1;
            checks++; if (in_allow !== 1'b1) $display("FAIL stream_in_allow[%0d] got %b want 1", i, in_allow); else passed++;
            step();
            checks++; if (out_valid !== 1'b1) $display("FAIL stream_out_valid[%0d] got %b want 1", i, out_valid); else passed++;
            checks++; if (out_payload !== exp_pl[i]) $display("FAIL stream_payload[%0d] got %h want %h", i, out_payload, exp_pl[i]); else passed++;
        end
        checks++; if (out_ex !== 6'h2A) $display("FAIL stream_ex got %h want 2a", out_ex); else passed++;
        in_valid = 1'b0; in_ex = '0;
        step();
        checks++; if (out_valid !== 1'b0) $display("FAIL stream_drain got %b want 0", out_valid); else passed++;
    endtask

    task automatic test_backpressure();
        in_valid = 1'b1; in_payload = 64'hAA; out_allow = 1'b0; in_need_late = 1'b0;
        step();
        in_payload = 64'hBB;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (in_allow !== 1'b0) $display("FAIL bp_in_allow[%0d] got %b want 0", i, in_allow); else passed++;
            step();
            checks++; if (out_payload !== 64'hAA) $display("FAIL bp_hold[%0d] got %h want aa", i, out_payload); else passed++;
        end
        out_allow = 1'b1;
        #1;
        checks++; if (in_allow !== 1'b1) $display("FAIL bp_release_allow got %b want 1", in_allow); else passed++;
        step();
        checks++; if (out_payload !== 64'hBB) $display("FAIL bp_next got %h want bb", out_payload); else passed++;
        checks++; if (out_valid !== 1'b1) $display("FAIL bp_next_valid got %b want 1", out_valid); else passed++;
        in_valid = 1'b0;
        step();
    endtask

    task automatic test_late();
        in_valid = 1'b1; in_payload = 64'h10; in_need_late = 1'b1; out_allow = 1'b1;
        step();
        in_valid = 1'b0; in_need_late = 1'b0;
        checks++; if (out_valid !== 1'b0) $display("FAIL late_wait_valid got %b want 0", out_valid); else passed++;
        checks++; if (in_allow !== 1'b0) $display("FAIL late_wait_allow got %b want 0", in_allow); else passed++;
        checks++; if (out_late_data !== 64'h0) $display("FAIL late_cleared got %h want 0", out_late_data); else passed++;
        repeat (4) step();
        checks++; if (out_valid !== 1'b0) $display("FAIL late_still_wait got %b want 0", out_valid); else passed++;
        late_valid = 1'b1; late_data = 64'hDEAD;
        step();
        late_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) $display("FAIL late_full_valid got %b want 1", out_valid); else passed++;
        checks++; if (out_late_data !== 64'hDEAD) $display("FAIL late_capture got %h want dead", out_late_data); else passed++;
        checks++; if (out_payload !== 64'h10) $display("FAIL late_payload got %h want 10", out_payload); else passed++;
    endtask

    task automatic test_spurious_late();
        // Stage is FULL holding 0x10 / 0xDEAD from the previous scenario.
        out_allow = 1'b0; late_valid = 1'b1; late_data = 64'hBEEF;
        step();
        late_valid = 1'b0;
        checks++; if (out_late_data !== 64'hDEAD) $display("FAIL spur_full_late got %h want dead", out_late_data); else passed++;
        checks++; if (out_valid !== 1'b1) $display("FAIL spur_full_state got %b want 1", out_valid); else passed++;
        out_allow = 1'b1;
        step();
        late_valid = 1'b1; late_data = 64'h1234;
        step();
        late_valid = 1'b0;
        checks++; if (out_valid !== 1'b0) $display("FAIL spur_empty_state got %b want 0", out_valid); else passed++;
        checks++; if (in_allow !== 1'b1) $display("FAIL spur_empty_allow got %b want 1", in_allow); else passed++;
        checks++; if (out_late_data !== 64'hDEAD) $display("FAIL spur_empty_late got %h want dead", out_late_data); else passed++;
    endtask

    task automatic test_flush();
        in_valid = 1'b1; in_payload = 64'hAA; out_allow = 1'b0; in_need_late = 1'b0;
        step();
        flush_req = 3'b010; out_allow = 1'b1; in_payload = 64'hCC;
        step();
        flush_req = '0; in_valid = 1'b0;
        checks++; if (out_valid !== 1'b0) $display("FAIL flush_full_valid got %b want 0", out_valid); else passed++;
        checks++; if (out_payload !== 64'hAA) $display("FAIL flush_blocked got %h want aa", out_payload); else passed++;
        checks++; if (in_allow !== 1'b1) $display("FAIL flush_empty_allow got %b want 1", in_allow); else passed++;
        in_valid = 1'b1; in_payload = 64'h20; in_need_late = 1'b1;
        step();
        in_valid = 1'b0; in_need_late = 1'b0;
        flush_req = 3'b100; late_valid = 1'b1; late_data = 64'h5555;
        step();
        flush_req = '0; late_valid = 1'b0;
        checks++; if (out_valid !== 1'b0) $display("FAIL flush_wait_valid got %b want 0", out_valid); else passed++;
        checks++; if (in_allow !== 1'b1) $display("FAIL flush_wait_allow got %b want 1", in_allow); else passed++;
        checks++; if (out_late_data !== 64'h0) $display("FAIL flush_wait_late got %h want 0", out_late_data); else passed++;
    endtask

    task automatic test_async_reset();
        in_valid = 1'b1; in_payload = 64'h30; in_ex = 6'h05; in_need_late = 1'b1; out_allow = 1'b1;
        step();
        in_valid = 1'b0; in_need_late = 1'b0; in_ex = '0;
        checks++; if (in_allow !== 1'b0) $display("FAIL ar_in_wait got %b want 0", in_allow); else passed++;
        #2;
        resetn = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) $display("FAIL ar_valid got %b want 0", out_valid); else passed++;
        checks++; if (out_payload !== 64'h0) $display("FAIL ar_payload got %h want 0", out_payload); else passed++;
        checks++; if (out_ex !== 6'h0) $display("FAIL ar_ex got %h want 0", out_ex); else passed++;
        checks++; if (in_allow !== 1'b1) $display("FAIL ar_allow got %b want 1", in_allow); else passed++;
        @(negedge clock);
        resetn = 1'b1;
        step();
        checks++; if (in_allow !== 1'b1) $display("FAIL ar_release_allow got %b want 1", in_allow); else passed++;
        checks++; if (out_valid !== 1'b0) $display("FAIL ar_release_valid got %b want 0", out_valid); else passed++;
    endtask

    initial begin
        checks = 0;
        passed = 0;
        test_reset();
        test_stream();
        test_backpressure();
        test_late();
        test_spurious_late();
        test_flush();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
